// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, N data bits (either order), optional even parity, stop bit.
// Optional parity stage enabled by defining SERIAL_RX_PARITY_EN.
`timescale 1ns/1ps
module serial_frame_rx #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_enable,
    input  logic         i_dir,
    input  logic         i_sin,
    output logic [N-1:0] o_data_out,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_parity_err,
    output logic         o_frame_err,
    output logic         o_overrun,
    output logic         o_busy
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY = 2'd3,
`endif
        S_STOP   = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [N-1:0]   r_shift;
    logic [CW-1:0]  r_cnt;
    logic           r_dir;
    logic [N-1:0]   r_data;
    logic           r_valid;
    logic           r_ferr;
    logic           r_ovr;

    logic           w_start;
    logic           w_shift;
    logic           w_stop_ok;
    logic           w_stop_bad;
    logic           w_load;
    logic           w_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_enable && i_sin) w_next = S_DATA;
            S_DATA:   if (i_enable && (r_cnt == CW'(N-1)))
`ifdef SERIAL_RX_PARITY_EN
                          w_next = S_PARITY;
            S_PARITY: if (i_enable) w_next = S_STOP;
`else
                          w_next = S_STOP;
`endif
            S_STOP:   if (i_enable) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_start    = i_enable && (r_state == S_IDLE) && i_sin;
        w_shift    = i_enable && (r_state == S_DATA);
        w_stop_ok  = i_enable && (r_state == S_STOP) && !i_sin;
        w_stop_bad = i_enable && (r_state == S_STOP) && i_sin;
        // A handshake on the stop edge frees the holding register in time for the new word.
        w_load     = w_stop_ok && (!r_valid || i_ready);
        w_drop     = w_stop_ok && r_valid && !i_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt <= '0;
                r_dir <= i_dir;
            end else if (w_shift) begin
                r_cnt <= r_cnt + CW'(1);
                if (r_dir) r_shift <= {i_sin, r_shift[N-1:1]};
                else       r_shift <= {r_shift[N-2:0], i_sin};
            end
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
            r_ferr <= w_stop_bad;
            r_ovr  <= w_drop;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    logic r_par_bit;
    logic r_perr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            if (i_enable && (r_state == S_PARITY)) r_par_bit <= i_sin;
            if (w_load) r_perr <= (^r_shift) ^ r_par_bit;
        end
    end

    assign o_parity_err = r_perr;
`else
    assign o_parity_err = 1'b0;
`endif

    assign o_data_out  = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_ferr;
    assign o_overrun   = r_ovr;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: directed frames, monitor pops expected words on handshake.
`timescale 1ns/1ps
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       rst, en, dir, sin, ready;
    logic [7:0] data_out;
    logic       valid, perr, ferr, ovr, busy;

`ifdef SERIAL_RX_PARITY_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    serial_frame_rx #(.N(8)) dut (
        .clk(clk), .rst(rst), .i_enable(en), .i_dir(dir), .i_sin(sin),
        .o_data_out(data_out), .o_valid(valid), .i_ready(ready),
        .o_parity_err(perr), .o_frame_err(ferr), .o_overrun(ovr), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int         checks = 0, failures = 0;
    logic [8:0] exp_q[$];
    int         exp_ferr = 0, exp_ovr = 0, seen_ferr = 0, seen_ovr = 0;
    bit         toggle = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pulse counting and word comparison on every accepted handshake
    always @(negedge clk) begin : monitor
        logic [8:0] e;
        if (!rst) begin
            if (ferr) seen_ferr++;
            if (ovr)  seen_ovr++;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", data_out, e[7:0]);
                    check("word_perr", perr, e[8]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        en  = 1'b1;
        tick();
        if (toggle) begin
            en  = 1'b0;
            sin = ~b;
            tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] w, input logic lsb, input logic par,
                              input logic stop, input logic rdy_at_stop);
        dir = lsb;
        send_bit(1'b1);
        dir = ~lsb;
        for (int i = 0; i < 8; i++) send_bit(lsb ? w[i] : w[7-i]);
`ifdef SERIAL_RX_PARITY_EN
        send_bit(par);
`else
        if (par) dir = ~lsb;
`endif
        if (rdy_at_stop) ready = 1'b1;
        send_bit(stop);
        sin = 1'b0;
        en  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; dir = 1'b0; sin = 1'b0; ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        check("idle_data", data_out, 8'h00);
        check("idle_valid", valid, 0);
        check("idle_ferr", ferr, 0);
        check("idle_ovr", ovr, 0);
        check("idle_perr", perr, 0);

        // LSB-first A5, valid for exactly one cycle with ready high
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_valid", valid, 1);
        check("t1_busy", busy, 0);
        check("t1_ferr", ferr, 0);
        tick();
        check("t1_valid_drop", valid, 0);

        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        toggle = 1'b1;
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        toggle = 1'b0;
        tick();

        // Bad stop bit
        exp_ferr++;
        send_frame(8'h77, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t4_ferr", ferr, 1);
        check("t4_valid", valid, 0);
        check("t4_busy", busy, 0);
        tick();
        check("t4_ferr_end", ferr, 0);

        // Overrun with ready low, then handshake on the stop edge
        ready = 1'b0;
        exp_q.push_back({1'b0, 8'h3C});
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_valid", valid, 1);
        check("t5_data", data_out, 8'h3C);
        exp_ovr++;
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_ovr", ovr, 1);
        check("t5_data_held", data_out, 8'h3C);
        tick();
        check("t5_ovr_end", ovr, 0);
        check("t5_valid_held", valid, 1);
        exp_q.push_back({1'b0, 8'hC3});
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t5_replace_data", data_out, 8'hC3);
        check("t5_replace_valid", valid, 1);
        check("t5_replace_ovr", ovr, 0);
        tick();
        check("t5_drained", valid, 0);

        // Parity: 01 has odd weight, so parity bit 0 is wrong and 1 is right
        exp_q.push_back({PAR_ON, 8'h01});
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        exp_q.push_back({1'b0, 8'h01});
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();

        // Reset after the 4th data bit
        dir = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("t7_busy_mid", busy, 1);
        rst = 1'b1;
        tick();
        check("t7_busy", busy, 0);
        check("t7_valid", valid, 0);
        check("t7_data", data_out, 8'h00);
        check("t7_ferr", ferr, 0);
        check("t7_ovr", ovr, 0);
        rst = 1'b0;
        sin = 1'b0;
        en  = 1'b0;
        tick();
        exp_q.push_back({1'b0, 8'h5A});
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t7_data_new", data_out, 8'h5A);
        repeat (3) tick();

        check("ferr_cycles", seen_ferr, exp_ferr);
        check("ovr_cycles", seen_ovr, exp_ovr);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
